// File: rtl/ysyx_22050854_divider_pkg.sv
// Shared constants, FSM encoding and sign helpers for the iterative divider.
package ysyx_22050854_divider_pkg;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned ITER_DW = 64;
   localparam int unsigned ITER_W  = 32;
   localparam int unsigned CNT_W   = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic [XLEN-1:0] sext_word(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

   // Unsigned magnitude; word mode yields a zero-extended 32-bit magnitude.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                 input logic neg, input logic word);
      logic [31:0] lo;
      lo = neg ? -v[31:0] : v[31:0];
      if (word) return {{(XLEN-32){1'b0}}, lo};
      return neg ? -v : v;
   endfunction

   // Restore sign to a magnitude; word results are sign-extended from bit 31.
   function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag,
                                                  input logic neg, input logic word);
      logic [31:0] lo;
      lo = neg ? -mag[31:0] : mag[31:0];
      if (word) return sext_word(lo);
      return neg ? -mag : mag;
   endfunction

endpackage

// File: rtl/ysyx_22050854_div_step.sv
// One combinational restoring-division step on a {rem, quo} pair.
module ysyx_22050854_div_step
   import ysyx_22050854_divider_pkg::*;
(
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0]   rem_sh;
   logic [XLEN-1:0] diff;
   logic            ge;

   // The shifted remainder needs one extra bit because the divisor may use all 64.
   assign rem_sh = {rem_i, quo_i[XLEN-1]};
   assign ge     = rem_sh >= {1'b0, dvs_i};
   assign diff   = rem_sh[XLEN-1:0] - dvs_i;
   assign rem_o  = ge ? diff : rem_sh[XLEN-1:0];
   assign quo_o  = {quo_i[XLEN-2:0], ge};

endmodule

// File: rtl/ysyx_22050854_divider.sv
// Iterative restoring divider for RV64 DIV/DIVU/REM/REMU and their *W forms.
module ysyx_22050854_divider #(
   parameter int unsigned XLEN = ysyx_22050854_divider_pkg::XLEN
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            div_valid,
   input  logic            divw,
   input  logic            div_signed,
   input  logic            flush,
   output logic            div_ready,
   output logic            out_valid,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);
   import ysyx_22050854_divider_pkg::state_e;
   import ysyx_22050854_divider_pkg::IDLE;
   import ysyx_22050854_divider_pkg::BUSY;
   import ysyx_22050854_divider_pkg::DONE;
   import ysyx_22050854_divider_pkg::ITER_DW;
   import ysyx_22050854_divider_pkg::ITER_W;
   import ysyx_22050854_divider_pkg::CNT_W;
   import ysyx_22050854_divider_pkg::sext_word;
   import ysyx_22050854_divider_pkg::magnitude;
   import ysyx_22050854_divider_pkg::apply_sign;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last;
   logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic             divw_q, divw_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  quotient_q, quotient_d, remainder_q, remainder_d;
   logic [XLEN-1:0]  step_rem, step_quo, a_mag;
   logic             a_neg, b_neg, div_zero, ovf;

   ysyx_22050854_div_step u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   assign a_neg    = div_signed & (divw ? dividend[31] : dividend[XLEN-1]);
   assign b_neg    = div_signed & (divw ? divisor[31]  : divisor[XLEN-1]);
   assign a_mag    = magnitude(dividend, a_neg, divw);
   assign div_zero = divw ? (divisor[31:0] == '0) : (divisor == '0);
   assign ovf      = div_signed & (divw ?
                     (dividend[31:0] == 32'h8000_0000 && divisor[31:0] == '1) :
                     (dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == '1));
   assign cnt_last = divw_q ? CNT_W'(ITER_W - 1) : CNT_W'(ITER_DW - 1);

   // NOTE: every variable gets a default first, so no path through the case can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      divw_d      = divw_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      out_valid_d = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      unique case (state_q)
         IDLE: if (div_valid && !flush) begin
            divw_d  = divw;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            cnt_d   = '0;
            rem_d   = '0;
            // Word mode parks the operand in the upper half so 32 shifts consume it.
            quo_d   = divw ? {a_mag[31:0], 32'h0} : a_mag;
            dvs_d   = magnitude(divisor, b_neg, divw);
            if (div_zero) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               quotient_d  = '1;
               remainder_d = divw ? sext_word(dividend[31:0]) : dividend;
            end else if (ovf) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               quotient_d  = divw ? sext_word(dividend[31:0]) : dividend;
               remainder_d = '0;
            end else begin
               state_d = BUSY;
            end
         end
         BUSY: if (flush) begin
            state_d = IDLE;
         end else begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == cnt_last) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               quotient_d  = apply_sign(step_quo, q_neg_q, divw_q);
               remainder_d = apply_sign(step_rem, r_neg_q, divw_q);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         divw_q      <= 1'b0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         out_valid_q <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         divw_q      <= divw_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         out_valid_q <= out_valid_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign div_ready = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: tb/tb_ysyx_22050854_divider.sv
// Scoreboard bench: directed divisions with hand-computed results and latencies.
module tb_ysyx_22050854_divider;

   logic        clock = 1'b0;
   logic        reset;
   logic [63:0] dividend, divisor;
   logic        div_valid, divw, div_signed, flush;
   logic        div_ready, out_valid;
   logic [63:0] quotient, remainder;

   typedef struct {
      logic [63:0] q;
      logic [63:0] r;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   ysyx_22050854_divider #(.XLEN(64)) dut (
      .clock      (clock),
      .reset      (reset),
      .dividend   (dividend),
      .divisor    (divisor),
      .div_valid  (div_valid),
      .divw       (divw),
      .div_signed (div_signed),
      .flush      (flush),
      .div_ready  (div_ready),
      .out_valid  (out_valid),
      .quotient   (quotient),
      .remainder  (remainder)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every out_valid pulse must match the oldest expected result.
   always @(negedge clock) begin
      if (!reset && out_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("latency_cycle", 64'(cyc), 64'(e.due));
            check("ready_in_done", 64'(div_ready), 64'd0);
         end
      end
   end

   task automatic wait_ready();
      int waited = 0;
      while (!div_ready && waited < 300) begin
         @(negedge clock);
         waited++;
      end
      if (!div_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL ready_timeout: got div_ready=0 expected 1 within 300 cycles");
      end
   endtask

   task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic w,
                        input logic s, input bit push, input logic [63:0] eq,
                        input logic [63:0] er, input int lat);
      exp_t e;
      wait_ready();
      dividend   = a;
      divisor    = b;
      divw       = w;
      div_signed = s;
      div_valid  = 1'b1;
      if (push) begin
         e.q   = eq;
         e.r   = er;
         e.due = cyc + lat;
         sb.push_back(e);
      end
      @(negedge clock);
      div_valid  = 1'b0;
      dividend   = ~a;
      divisor    = ~b;
      divw       = ~w;
      div_signed = ~s;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; dividend = '0; divisor = '0;
      div_valid = 1'b0; divw = 1'b0; div_signed = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("reset_quotient", quotient, 64'd0);
      check("reset_remainder", remainder, 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_ready", 64'(div_ready), 64'd1);

      issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      issue(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
      issue(64'hFFFF_FFFF_8000_0000, 64'd3, 1, 0, 1, 64'h0000_0000_2AAA_AAAA, 64'd2, 33);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 64'd1, 64'd1, 65);
      issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 64'd0, 64'h8000_0000_0000_0000, 65);
      issue(64'h0000_0000_FFFF_FFF9, 64'd2, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33);
      issue(64'h0000_0001_FFFF_FFFF, 64'd1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33);
      issue(64'd42, 64'd0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 1);
      issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1, 64'h8000_0000_0000_0000, 64'd0, 1);
      issue(64'h1234_5678_8000_0001, 64'h0000_0005_0000_0000, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1);
      issue(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 1, 1, 64'hFFFF_FFFF_8000_0000, 64'd0, 1);

      // Flush ten cycles into BUSY: no result, ready next cycle.
      issue(64'd1000, 64'd3, 0, 0, 0, 64'd0, 64'd0, 0);
      repeat (9) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check("flush_ready", 64'(div_ready), 64'd1);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      issue(64'd100, 64'd7, 0, 0, 1, 64'd14, 64'd2, 65);

      // Reset mid-BUSY, with a request pending that reset must override.
      issue(64'd12345, 64'd11, 0, 0, 0, 64'd0, 64'd0, 0);
      repeat (20) @(negedge clock);
      reset = 1'b1; div_valid = 1'b1; dividend = 64'd42; divisor = 64'd0;
      @(negedge clock);
      reset = 1'b0; div_valid = 1'b0;
      check("midreset_quotient", quotient, 64'd0);
      check("midreset_remainder", remainder, 64'd0);
      check("midreset_out_valid", 64'(out_valid), 64'd0);
      check("midreset_ready", 64'(div_ready), 64'd1);
      @(negedge clock);
      check("post_reset_ready", 64'(div_ready), 64'd1);

      // Request together with flush in IDLE is not accepted.
      div_valid = 1'b1; flush = 1'b1; dividend = 64'd42; divisor = 64'd0;
      @(negedge clock);
      div_valid = 1'b0; flush = 1'b0;
      check("flush_wins_ready", 64'(div_ready), 64'd1);
      check("flush_wins_out_valid", 64'(out_valid), 64'd0);
      repeat (3) @(negedge clock);
      check("flush_wins_ready_later", 64'(div_ready), 64'd1);

      begin
         int waited = 0;
         while (sb.size() != 0 && waited < 300) begin
            @(negedge clock);
            waited++;
         end
         if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
         end
      end
      repeat (5) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22050854_divider.md
YSYX_22050854_DIVIDER -- requirements
Module: ysyx_22050854_divider

Interface
REQ-001 Parameter XLEN, default 64, operand/result width; only 64 is supported.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dividend  input  XLEN  dividend operand, sampled at accept.
REQ-005 divisor  input  XLEN  divisor operand, sampled at accept.
REQ-006 div_valid  input  1  request valid.
REQ-007 divw  input  1  word mode: operate on low 32 bits, sign-extend 32-bit results to XLEN.
REQ-008 div_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-009 flush  input  1  abort any in-flight operation.
REQ-010 div_ready  output  1  high only in IDLE; the block can accept a request.
REQ-011 out_valid  output  1  one-cycle pulse; quotient/remainder are valid.
REQ-012 quotient  output  XLEN  result quotient.
REQ-013 remainder  output  XLEN  result remainder.

Function
REQ-014 FSM states: IDLE, BUSY, DONE.
REQ-015 Accept = div_valid && div_ready && !flush at a rising edge; operands, divw and div_signed are latched at accept and inputs are ignored afterwards.
REQ-016 IDLE->BUSY on a normal accept; IDLE->DONE on an accept with divisor zero or signed overflow.
REQ-017 Iteration count N is 64 in doubleword mode and 32 in word mode. BUSY runs one restoring step per cycle, then BUSY->DONE after exactly N steps.
REQ-018 Each step: shift {rem,quo} left 1; trial = rem - |divisor|; if trial is non-negative, rem = trial and quo LSB = 1.
REQ-019 Signed operands are converted to magnitudes before iterating. Quotient is negated if operand signs differ. Remainder takes the sign of the dividend.
REQ-020 Latency, normal case: accept at edge T -> out_valid high in the cycle after edge T+N, i.e. N+1 cycles.
REQ-021 Latency, special cases: out_valid is high in the cycle after edge T (1 cycle).
REQ-022 DONE lasts exactly one cycle with out_valid=1, then DONE->IDLE unconditionally. quotient and remainder hold their value until the next DONE.
REQ-023 Division by zero: quotient = all ones (32 ones sign-extended in word mode); remainder = dividend (low 32 sign-extended in word mode).
REQ-024 Signed overflow (most-negative / -1 at the active width): quotient = dividend at that width, sign-extended; remainder = 0.
REQ-025 Word mode: only dividend[31:0] and divisor[31:0] are used. Both results are sign-extended from bit 31, for signed and unsigned alike (RV64 *W semantics).
REQ-026 flush in BUSY or DONE: next state IDLE, and out_valid is 0 in the following cycle.
REQ-027 flush together with div_valid in IDLE: no accept occurs; flush wins.
REQ-028 No back-pressure: out_valid is not qualified by any ready, and a result that is not captured is lost.
REQ-029 A new request may be accepted in the first IDLE cycle after DONE; there is no back-to-back accept during DONE.

Reset
REQ-030 When reset=1 at an edge: state=IDLE, out_valid=0, quotient=0, remainder=0, iteration counter=0, internal operand registers=0.
REQ-031 Reset overrides flush and div_valid in the same cycle.
REQ-032 Reset mid-BUSY aborts the operation with no out_valid.
REQ-033 div_ready=1 in the first cycle after reset deasserts.

Structure
REQ-034 A shared package holds: XLEN, FSM state encodings, and the iteration-count constants 64 and 32.
REQ-035 One sub-module ysyx_22050854_div_step implements a single combinational restoring step (REQ-018) and is instantiated once.
REQ-036 The counter, FSM, sign fix-up and special-case detection stay in the top module.
REQ-037 Output registers are driven only from DONE entry; there is no combinational path from inputs to outputs except div_ready from state.

Verification
REQ-038 Signed doubleword: dividend=-7, divisor=2, div_signed=1 -> after 65 cycles out_valid=1 with quotient=-3, remainder=-1.
REQ-039 Unsigned word: dividend=0xFFFF_FFFF_8000_0000, divisor=3, divw=1, div_signed=0 -> after 33 cycles quotient=0x0000_0000_2AAA_AAAA, remainder=0x0000_0000_0000_0002.
REQ-040 Divide by zero: dividend=42, divisor=0 -> out_valid next cycle with quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=42.
REQ-041 Signed overflow: dividend=0x8000_0000_0000_0000, divisor=-1, signed -> out_valid next cycle with quotient=0x8000_0000_0000_0000, remainder=0.
REQ-042 Flush at cycle 10 of BUSY -> div_ready=1 the next cycle and no out_valid; a following 100/7 unsigned request -> quotient=14, remainder=2.
REQ-043 Reset asserted mid-BUSY -> outputs zero, IDLE, no out_valid; div_valid together with flush in IDLE -> no accept, div_ready stays 1.
